rv32_alu_multicycle: RTL and testbench
======================================

Name: rv32_alu_multicycle

Overview:
- Multicycle 32-bit integer ALU for the multicycle RV32 core's execute stage.
- Computes ADD/SUB/AND/OR one SLICE_W-bit slice per clock, rippling the carry between slices.
- Signals completion with o_data_valid; the control FSM waits on that flag before writeback.

Parameters:
- SLICE_W, 8: bits processed per cycle. Must divide 32. Execute latency is 32/SLICE_W cycles (4 at default).

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_en_alu  in  1  start request; sampled only in IDLE.
- i_operand_one  in  32  operand A.
- i_operand_two  in  32  operand B.
- i_alu_sel  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- i_stall_reset  in  1  1 = hold DONE while i_en_alu stays high; 0 = DONE lasts exactly one cycle.
- o_carry_out  out  1  carry/no-borrow of the last operation.
- o_data_valid  out  1  result and carry valid (high only in DONE).
- o_result  out  32  result register.

Behaviour:
- Reset (i_rst=0, async):
  - state=IDLE.
  - o_result=0, o_carry_out=0, o_data_valid=0.
  - Internal operand, sel and slice-index registers cleared.
  - Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE, EXEC, DONE (2-bit encoding).
- IDLE:
  - On an edge with i_en_alu=1: latch A, B and sel; clear o_result and carry chain; slice index=0; go to EXEC.
  - Carry-in is 1 for SUB, 0 otherwise.
  - Otherwise stay in IDLE; outputs hold.
- EXEC, each edge computes slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W):
  - ADD: A_k + B_k + c.
  - SUB: A_k + ~B_k + c.
  - AND: A_k & B_k.
  - OR: A_k | B_k.
  - Result slice is written into o_result; slice carry is stored as c for the next slice; k increments.
  - After the last slice: o_carry_out = final c for ADD/SUB, 0 for AND/OR; o_data_valid<=1; go to DONE.
- Latency: o_data_valid rises on the (32/SLICE_W)-th edge after the accept edge (4 at default); that is ≤5 clocks from request.
- Input and enable changes during EXEC:
  - i_en_alu and operand/sel changes are ignored; latched values are used.
  - Deasserting i_en_alu does not cancel the operation.
- DONE:
  - i_stall_reset=1: stay in DONE with o_data_valid=1 while i_en_alu=1. When i_en_alu=0, go to IDLE and clear o_data_valid.
  - i_stall_reset=0: leave for IDLE after one cycle, regardless of i_en_alu. A new op is accepted from IDLE on a later edge, never directly from DONE.
- o_result and o_carry_out hold their value after DONE until the next accept clears them.
- o_result is only architecturally meaningful while o_data_valid=1; during EXEC it shows the completed lower slices and zeros above.
- SUB carry semantics: carry_out=1 means A≥B unsigned (no borrow).
- Widths: all arithmetic is modulo 2^32; no sign extension.

Optional Feature:
- Macro RV32_ALU_FSM_OVERFLOW_EN.
- Defined: adds port o_overflow (out, 1).
  - Signed overflow of ADD/SUB, computed from the operand and result MSBs on the final slice.
  - 0 for AND/OR.
  - Same reset, update and hold timing as o_carry_out.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package rv32_alu_pkg:
  - alu_sel_e enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
  - alu_state_e enum (IDLE, EXEC, DONE).
  - Localparam XLEN=32.
- One sub-module rv32_alu_slice: combinational SLICE_W-bit slice.
  - Inputs: a, b, carry_in, sel.
  - Outputs: result, carry_out.
  - Instantiated once; the top handles sequencing and muxing.

Test Plan:
- ADD 0x0000_0005 + 0x0000_0003 -> o_result=0x0000_0008, carry=0, valid on 4th edge after accept.
- ADD 0xFFFF_FFFF + 0x0000_0001 -> o_result=0x0000_0000, carry=1; ripple crosses all slices.
- SUB 0x0000_0003 - 0x0000_0005 -> o_result=0xFFFF_FFFE, carry=0. SUB 0x10 - 0x10 -> 0x0, carry=1.
- AND 0xF0F0_1234 & 0x0FF0_FFFF -> 0x00F0_1234. OR 0xF000_0000 | 0x0000_000F -> 0xF000_000F. Carry=0 in both.
- Hold handshake:
  - i_stall_reset=1 with i_en_alu held high -> valid stays 1 for 10 cycles.
  - Drop i_en_alu -> IDLE next edge, valid=0.
  - i_stall_reset=0 -> valid high exactly one cycle.
- Async reset mid-EXEC:
  - Assert i_rst=0 between edges -> outputs 0 immediately.
  - Release, then a new ADD 1+1 -> 0x2 with normal latency.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// Shared types for the multicycle RV32 ALU: operation select, FSM states, datapath width.
package rv32_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/rv32_alu_slice.sv
// Combinational W-bit ALU slice; the top ripples carry_out into the next slice's carry_in.
module rv32_alu_slice
  import rv32_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  input  alu_sel_e     sel,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W:0] sum;

  always_comb begin
    sum       = '0;
    result    = '0;
    carry_out = 1'b0;
    case (sel)
      ALU_ADD: begin
        sum       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
        result    = sum[W-1:0];
        carry_out = sum[W];
      end
      // Subtraction as A + ~B + 1; the +1 arrives as the first slice's carry_in.
      ALU_SUB: begin
        sum       = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, carry_in};
        result    = sum[W-1:0];
        carry_out = sum[W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_alu_multicycle.sv
// Multicycle 32-bit ALU: one SLICE_W-bit slice per clock with rippled carry.
// Optional signed-overflow output enabled by defining RV32_ALU_FSM_OVERFLOW_EN.
module rv32_alu_multicycle
  import rv32_alu_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en_alu,
  input  logic [31:0] i_operand_one,
  input  logic [31:0] i_operand_two,
  input  logic [1:0]  i_alu_sel,
  input  logic        i_stall_reset,
  output logic        o_carry_out,
  output logic        o_data_valid,
`ifdef RV32_ALU_FSM_OVERFLOW_EN
  output logic        o_overflow,
`endif
  output logic [31:0] o_result
);

  localparam int NUM_SLICES = XLEN / SLICE_W;
  localparam int K_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  alu_state_e      state_reg, state_next;
  logic [XLEN-1:0] a_reg, b_reg;
  alu_sel_e        sel_reg;
  logic [K_W-1:0]  k_reg;
  logic            c_reg;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_res;
  logic               slice_c;
  logic               last_slice;
  logic               is_arith;

  assign slice_a    = a_reg[k_reg*SLICE_W +: SLICE_W];
  assign slice_b    = b_reg[k_reg*SLICE_W +: SLICE_W];
  assign last_slice = (k_reg == K_W'(NUM_SLICES - 1));
  assign is_arith   = (sel_reg == ALU_ADD) || (sel_reg == ALU_SUB);

  rv32_alu_slice #(.W(SLICE_W)) u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (c_reg),
    .sel       (sel_reg),
    .result    (slice_res),
    .carry_out (slice_c)
  );

`ifdef RV32_ALU_FSM_OVERFLOW_EN
  // On the final slice slice_res holds the result MSB; overflow when the sign is inconsistent.
  logic ovf_next;
  always_comb begin
    ovf_next = 1'b0;
    if (sel_reg == ALU_ADD)
      ovf_next = (a_reg[XLEN-1] == b_reg[XLEN-1]) && (slice_res[SLICE_W-1] != a_reg[XLEN-1]);
    else if (sel_reg == ALU_SUB)
      ovf_next = (a_reg[XLEN-1] != b_reg[XLEN-1]) && (slice_res[SLICE_W-1] != a_reg[XLEN-1]);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_en_alu) state_next = EXEC;
      EXEC:    if (last_slice) state_next = DONE;
      DONE:    if (!(i_stall_reset && i_en_alu)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sel_reg      <= ALU_ADD;
      k_reg        <= '0;
      c_reg        <= 1'b0;
      o_result     <= '0;
      o_carry_out  <= 1'b0;
      o_data_valid <= 1'b0;
`ifdef RV32_ALU_FSM_OVERFLOW_EN
      o_overflow   <= 1'b0;
`endif
    end else begin
      // Valid tracks occupancy of DONE exactly, including the stalled hold.
      o_data_valid <= (state_next == DONE);
      case (state_reg)
        IDLE: if (i_en_alu) begin
          a_reg       <= i_operand_one;
          b_reg       <= i_operand_two;
          sel_reg     <= alu_sel_e'(i_alu_sel);
          k_reg       <= '0;
          c_reg       <= (alu_sel_e'(i_alu_sel) == ALU_SUB);
          o_result    <= '0;
          o_carry_out <= 1'b0;
`ifdef RV32_ALU_FSM_OVERFLOW_EN
          o_overflow  <= 1'b0;
`endif
        end
        EXEC: begin
          o_result[k_reg*SLICE_W +: SLICE_W] <= slice_res;
          c_reg <= slice_c;
          k_reg <= k_reg + K_W'(1);
          if (last_slice) begin
            o_carry_out <= is_arith & slice_c;
`ifdef RV32_ALU_FSM_OVERFLOW_EN
            o_overflow  <= ovf_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_alu_multicycle.sv
// Randomized self-checking bench for rv32_alu_multicycle against an arithmetic reference model.
module tb_rv32_alu_multicycle;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en_alu = 1'b0;
  logic [31:0] i_operand_one = '0;
  logic [31:0] i_operand_two = '0;
  logic [1:0]  i_alu_sel = 2'b00;
  logic        i_stall_reset = 1'b0;
  logic        o_carry_out;
  logic        o_data_valid;
  logic [31:0] o_result;
`ifdef RV32_ALU_FSM_OVERFLOW_EN
  logic        o_overflow;
`endif

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  rv32_alu_multicycle #(.SLICE_W(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en_alu      (i_en_alu),
    .i_operand_one (i_operand_one),
    .i_operand_two (i_operand_two),
    .i_alu_sel     (i_alu_sel),
    .i_stall_reset (i_stall_reset),
    .o_carry_out   (o_carry_out),
    .o_data_valid  (o_data_valid),
`ifdef RV32_ALU_FSM_OVERFLOW_EN
    .o_overflow    (o_overflow),
`endif
    .o_result      (o_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result}; SUB carry means no borrow (A >= B unsigned).
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
    logic [32:0] r;
    case (sel)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a >= b), a - b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

`ifdef RV32_ALU_FSM_OVERFLOW_EN
  function automatic logic ovf_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
    longint s;
    if (sel == 2'b00)      s = longint'($signed(a)) + longint'($signed(b));
    else if (sel == 2'b01) s = longint'($signed(a)) - longint'($signed(b));
    else                   return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction
`endif

  // Called at #1 after a rising edge with the DUT in IDLE; returns in the same phase, IDLE, en low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic stall, input int hold, input string tag);
    logic [32:0] exp;
    int cyc;
    exp = model(a, b, sel);
    i_operand_one = a;
    i_operand_two = b;
    i_alu_sel     = sel;
    i_stall_reset = stall;
    i_en_alu      = 1'b1;
    @(posedge i_clk); #1;
    check({tag, "_accept_valid"}, 32'(o_data_valid), 32'd0);
    // Inputs are ignored once accepted: scramble them.
    i_operand_one = $urandom;
    i_operand_two = $urandom;
    i_alu_sel     = 2'($urandom);
    if (!stall) i_en_alu = 1'($urandom);
    cyc = 0;
    while (!o_data_valid && cyc < 20) begin
      @(posedge i_clk); #1;
      cyc++;
      if (!stall) i_en_alu = 1'($urandom);
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_result"}, o_result, exp[31:0]);
    check({tag, "_carry"}, 32'(o_carry_out), 32'(exp[32]));
`ifdef RV32_ALU_FSM_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(o_overflow), 32'(ovf_model(a, b, sel)));
`endif
    if (stall) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge i_clk); #1;
        check({tag, "_hold_valid"}, 32'(o_data_valid), 32'd1);
      end
      i_en_alu = 1'b0;
    end
    @(posedge i_clk); #1;
    i_en_alu = 1'b0;
    check({tag, "_drop_valid"}, 32'(o_data_valid), 32'd0);
    @(posedge i_clk); #1;
    check({tag, "_held_result"}, o_result, exp[31:0]);
    check({tag, "_held_carry"}, 32'(o_carry_out), 32'(exp[32]));
    $display("op %s a=%08h b=%08h sel=%0d stall=%0d -> result=%08h carry=%0d latency=%0d",
             tag, a, b, sel, stall, o_result, o_carry_out, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rs;
    logic        rst_stall;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_result", o_result, 32'd0);
    check("reset_carry", 32'(o_carry_out), 32'd0);
    check("reset_valid", 32'(o_data_valid), 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Directed vectors
    run_op(32'h0000_0005, 32'h0000_0003, 2'b00, 1'b0, 0, "add_small");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 0, "add_wrap");
    run_op(32'h0000_0003, 32'h0000_0005, 2'b01, 1'b0, 0, "sub_borrow");
    run_op(32'h0000_0010, 32'h0000_0010, 2'b01, 1'b0, 0, "sub_equal");
    run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10, 1'b0, 0, "and");
    run_op(32'hF000_0000, 32'h0000_000F, 2'b11, 1'b0, 0, "or");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 10, "add_stall10");
    run_op(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 0, "sub_signed_ovf");

    // Async reset in the middle of EXEC
    i_operand_one = 32'hFFFF_FFFF;
    i_operand_two = 32'hFFFF_FFFF;
    i_alu_sel     = 2'b00;
    i_stall_reset = 1'b0;
    i_en_alu      = 1'b1;
    @(posedge i_clk); #1;
    repeat (2) begin @(posedge i_clk); #1; end
    check("exec_partial", o_result, 32'h0000_FFFE);
    #2 i_rst = 1'b0;
    #1;
    check("async_rst_result", o_result, 32'd0);
    check("async_rst_valid", 32'(o_data_valid), 32'd0);
    check("async_rst_carry", 32'(o_carry_out), 32'd0);
    i_en_alu = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    run_op(32'd1, 32'd1, 2'b00, 1'b0, 0, "add_after_rst");

    // Random operations
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rs = 2'($urandom);
      rst_stall = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rs, rst_stall, int'($urandom_range(1, 5)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
